mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Bridges the multi-cycle controller's one-cycle memory strobes (MemRead, MemWrite, IorD, IRWrite) to a variable-latency req/ack memory bus.
//  It holds the controller with Stall until the bus acknowledges, then captures the read data into the instruction register (IR) or the MDR.
//  Sits directly downstream of the controller, between the controller/datapath and unified instruction/data memory.
//  Integration rule: datapath gates PCWrite, PCWriteCond, RegWrite and the controller state register with ~Stall.
// PARAMETERS
//  ADDR_W   32   bus address width
//  DATA_W   32   bus data width
//  TIMEOUT  255  max BUSY cycles waiting for bus_ack (1..2^TO_W-1)
//  TO_W     8    timeout counter width
// PORTS
//  clk          in   1       system clock, rising edge
//  reset        in   1       synchronous, active-low reset
//  MemRead      in   1       controller read strobe
//  MemWrite     in   1       controller write strobe
//  IorD         in   1       0: address=PC, 1: address=ALUOut
//  IRWrite      in   1       read destination: 1=IR, 0=MDR
//  PC           in   ADDR_W  fetch address
//  ALUOut       in   ADDR_W  data address
//  WriteData    in   DATA_W  store data (B register)
//  Stall        out  1       controller must hold current state
//  Instruction  out  DATA_W  IR contents (OpCode/Funct source)
//  MDR          out  DATA_W  memory data register
//  TimeoutErr   out  1       sticky: a transaction timed out
//  bus_req      out  1       request, held until ack
//  bus_we       out  1       1=write
//  bus_addr     out  ADDR_W  word-aligned byte address
//  bus_wdata    out  DATA_W  write data
//  bus_rdata    in   DATA_W  read data, valid with bus_ack
//  bus_ack      in   1       one-cycle completion
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE; all outputs, Instruction, MDR, TimeoutErr and the counter cleared to 0. Applies mid-transaction: bus_req drops at the same edge.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: request = MemRead|MemWrite. At the edge, latch addr (IorD ? ALUOut : PC), we=MemWrite (write wins if both are set), wdata, dst=IRWrite; counter=0; go to BUSY.
//  BUSY: bus_req=1. bus_we, bus_addr and bus_wdata are registered and stable while req=1. Counter increments every cycle.
//   - bus_ack=1: for a read, write bus_rdata into IR (dst=1) or MDR (dst=0); go to DONE.
//   - Counter reaches TIMEOUT-1 with no ack: drop req; a read writes 0 into dst (IR 0 = nop); set TimeoutErr; go to DONE.
//  DONE: Stall=0 for exactly one cycle. Strobes still asserted are ignored (the controller advances at this edge). Unconditionally go to IDLE.
//  Stall (combinational) = (IDLE & (MemRead|MemWrite)) | BUSY.
//  Latency: ack in BUSY cycle k (k>=1) gives Stall high for k+1 cycles; data is visible in the DONE cycle.
//  bus_ack outside BUSY is ignored. Instruction and MDR change only on completion or reset.
//  TimeoutErr is cleared only by reset.
// CONFIGURATION
//  MISALIGN_CHECK_EN defined:
//   - Adds output AddrErr (1 bit).
//   - An IDLE request whose selected address has [1:0]!=0 issues no bus_req and goes straight to DONE (Stall high 1 cycle).
//   - AddrErr pulses high in the DONE cycle; IR and MDR are unchanged.
//  MISALIGN_CHECK_EN not defined: no AddrErr port; the address is passed unchanged, including low bits.
// TESTING
//  1. reset=0 for 2 clk -> Stall, bus_req, Instruction, MDR, TimeoutErr all 0; state IDLE.
//  2. Fetch: PC=0x4, MemRead=1, IRWrite=1, IorD=0; ack in BUSY cycle 3 with 0x20080005 -> bus_addr=0x4, bus_we=0, Stall high 4 cycles, Instruction=0x20080005, MDR unchanged.
//  3. sw: MemWrite=1, IorD=1, ALUOut=0x10, WriteData=0xDEADBEEF; ack in BUSY cycle 1 -> bus_we=1, bus_wdata=0xDEADBEEF, Stall high 2 cycles.
//  4. TIMEOUT=4, lw with no ack -> bus_req low after 4 BUSY cycles, MDR=0, TimeoutErr=1 and still 1 after the next good transaction.
//  5. reset=0 in BUSY cycle 2 -> bus_req=0 and Stall=0 after the edge; a later ack is ignored.
//  6. MISALIGN_CHECK_EN: lw at ALUOut=0x12 -> no bus_req, Stall high 1 cycle, AddrErr 1 for 1 cycle, MDR unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: bridges the multi-cycle controller's one-cycle memory
// strobes onto a variable-latency req/ack bus. The controller is held with
// Stall until the bus acknowledges (or the wait times out), and read data is
// captured into the instruction register or the memory data register.
// Optional feature: define MISALIGN_CHECK_EN to add the AddrErr output and
// reject requests whose selected address is not word aligned.
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IorD,
    input  logic              IRWrite,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] WriteData,
    output logic              Stall,
    output logic [DATA_W-1:0] Instruction,
    output logic [DATA_W-1:0] MDR,
    output logic              TimeoutErr,
`ifdef MISALIGN_CHECK_EN
    output logic              AddrErr,
`endif
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [TO_W-1:0]   cnt_r;
    logic              dst_r;
    logic              bus_req_r;
    logic              bus_we_r;
    logic [ADDR_W-1:0] bus_addr_r;
    logic [DATA_W-1:0] bus_wdata_r;
    logic [DATA_W-1:0] instr_r;
    logic [DATA_W-1:0] mdr_r;
    logic              timeout_err_r;
`ifdef MISALIGN_CHECK_EN
    logic              addr_err_r;
`endif

    logic              req_s;
    logic [ADDR_W-1:0] addr_sel_s;
    logic              misalign_s;

    // Request decode and address selection for the IDLE cycle.
    assign req_s      = MemRead | MemWrite;
    assign addr_sel_s = IorD ? ALUOut : PC;
`ifdef MISALIGN_CHECK_EN
    assign misalign_s = |addr_sel_s[1:0];
`else
    assign misalign_s = 1'b0;
`endif

    // Stall must be combinational so the controller freezes in the very cycle it strobes.
    assign Stall = ((state_r == ST_IDLE) && req_s) || (state_r == ST_BUSY);

    // Output ports are driven straight from registers.
    assign bus_req     = bus_req_r;
    assign bus_we      = bus_we_r;
    assign bus_addr    = bus_addr_r;
    assign bus_wdata   = bus_wdata_r;
    assign Instruction = instr_r;
    assign MDR         = mdr_r;
    assign TimeoutErr  = timeout_err_r;
`ifdef MISALIGN_CHECK_EN
    assign AddrErr     = addr_err_r;
`endif

    // Transaction FSM: latch the request, wait for ack or timeout, release for one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {TO_W{1'b0}};
            dst_r         <= 1'b0;
            bus_req_r     <= 1'b0;
            bus_we_r      <= 1'b0;
            bus_addr_r    <= {ADDR_W{1'b0}};
            bus_wdata_r   <= {DATA_W{1'b0}};
            instr_r       <= {DATA_W{1'b0}};
            mdr_r         <= {DATA_W{1'b0}};
            timeout_err_r <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            addr_err_r    <= 1'b0;
`endif
        end else begin
`ifdef MISALIGN_CHECK_EN
            addr_err_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (req_s && misalign_s) begin
                        // Misaligned: skip the bus entirely and report in DONE.
                        state_r <= ST_DONE;
`ifdef MISALIGN_CHECK_EN
                        addr_err_r <= 1'b1;
`endif
                    end else if (req_s) begin
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= MemWrite;
                        bus_addr_r  <= addr_sel_s;
                        bus_wdata_r <= WriteData;
                        dst_r       <= IRWrite;
                        cnt_r       <= {TO_W{1'b0}};
                        state_r     <= ST_BUSY;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    cnt_r <= cnt_r + TO_W'(1);
                    if (bus_ack) begin
                        // An ack in the final allowed cycle still completes normally.
                        if (!bus_we_r) begin
                            if (dst_r) begin
                                instr_r <= bus_rdata;
                            end else begin
                                mdr_r <= bus_rdata;
                            end
                        end else begin
                            mdr_r <= mdr_r;
                        end
                        bus_req_r <= 1'b0;
                        state_r   <= ST_DONE;
                    end else if (cnt_r == TO_W'(TIMEOUT - 1)) begin
                        // Timed out reads load zero so a lost fetch executes as a nop.
                        if (!bus_we_r) begin
                            if (dst_r) begin
                                instr_r <= {DATA_W{1'b0}};
                            end else begin
                                mdr_r <= {DATA_W{1'b0}};
                            end
                        end else begin
                            mdr_r <= mdr_r;
                        end
                        bus_req_r     <= 1'b0;
                        timeout_err_r <= 1'b1;
                        state_r       <= ST_DONE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    // Strobes seen here belong to the finished access; ignore them.
                    state_r <= ST_IDLE;
                end
                default: begin
                    bus_req_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit (built with TIMEOUT=4).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, IorD, IRWrite;
    logic [31:0] PC, ALUOut, WriteData;
    logic        Stall;
    logic [31:0] Instruction, MDR;
    logic        TimeoutErr;
`ifdef MISALIGN_CHECK_EN
    logic        AddrErr;
`endif
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ack;

    int n_tests = 0;
    int n_fail  = 0;

    // Results captured by the transaction driver.
    int          t_stalls;
    logic        t_req1, t_we1, t_any_req;
    logic [31:0] t_addr1, t_wdata1;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PC(PC), .ALUOut(ALUOut), .WriteData(WriteData),
        .Stall(Stall), .Instruction(Instruction), .MDR(MDR), .TimeoutErr(TimeoutErr),
`ifdef MISALIGN_CHECK_EN
        .AddrErr(AddrErr),
`endif
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    // Drives one access, holding strobes while stalled; acks in BUSY cycle ack_at
    // (cycle 0 is the IDLE request cycle, -1 means never). Returns in the DONE cycle.
    task automatic drive_txn(input logic rd, input logic wr, input logic iord, input logic irw,
                             input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                             input int ack_at, input logic [31:0] rdata);
        int cyc;
        MemRead = rd; MemWrite = wr; IorD = iord; IRWrite = irw;
        PC = pc; ALUOut = alu; WriteData = wd;
        #1;
        cyc = 0; t_stalls = 0; t_any_req = 1'b0;
        t_req1 = 1'b0; t_we1 = 1'b0; t_addr1 = 32'h0; t_wdata1 = 32'h0;
        while (Stall === 1'b1 && cyc < 40) begin
            t_stalls++;
            t_any_req = t_any_req | bus_req;
            if (cyc == 1) begin
                t_req1 = bus_req; t_we1 = bus_we; t_addr1 = bus_addr; t_wdata1 = bus_wdata;
            end
            bus_ack   = (cyc == ack_at);
            bus_rdata = rdata;
            @(posedge clk); #1;
            cyc++;
        end
        bus_ack   = 1'b0;
        t_any_req = t_any_req | bus_req;
    endtask

    // Leaves the DONE cycle: controller drops its strobes.
    task automatic end_txn();
        MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", Stall); end
        n_tests++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus_req); end
        n_tests++; if (Instruction !== 32'h0) begin n_fail++; $display("FAIL reset_ir: got %h want 0", Instruction); end
        n_tests++; if (MDR !== 32'h0) begin n_fail++; $display("FAIL reset_mdr: got %h want 0", MDR); end
        n_tests++; if (TimeoutErr !== 1'b0) begin n_fail++; $display("FAIL reset_toerr: got %b want 0", TimeoutErr); end
        n_tests++; if ({bus_we, bus_addr, bus_wdata} !== 65'h0) begin n_fail++; $display("FAIL reset_bus: got we=%b a=%h d=%h want 0", bus_we, bus_addr, bus_wdata); end
`ifdef MISALIGN_CHECK_EN
        n_tests++; if (AddrErr !== 1'b0) begin n_fail++; $display("FAIL reset_adderr: got %b want 0", AddrErr); end
`endif
        reset = 1'b1;
    endtask

    task automatic test_fetch();
        drive_txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 32'h100, 32'h0, 3, 32'h20080005);
        n_tests++; if (t_stalls != 4) begin n_fail++; $display("FAIL fetch_stall_len: got %0d want 4", t_stalls); end
        n_tests++; if (t_req1 !== 1'b1 || t_we1 !== 1'b0) begin n_fail++; $display("FAIL fetch_req_we: got req=%b we=%b want 1 0", t_req1, t_we1); end
        n_tests++; if (t_addr1 !== 32'h4) begin n_fail++; $display("FAIL fetch_addr: got %h want 00000004", t_addr1); end
        n_tests++; if (Instruction !== 32'h20080005) begin n_fail++; $display("FAIL fetch_ir: got %h want 20080005", Instruction); end
        n_tests++; if (MDR !== 32'h0) begin n_fail++; $display("FAIL fetch_mdr: got %h want 0", MDR); end
        n_tests++; if (Stall !== 1'b0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL fetch_done: got stall=%b req=%b want 0 0", Stall, bus_req); end
        end_txn();
        n_tests++; if (bus_req !== 1'b0 || Stall !== 1'b0) begin n_fail++; $display("FAIL done_ignores_strobes: got req=%b stall=%b want 0 0", bus_req, Stall); end
    endtask

    task automatic test_store();
        // MemRead also set: write must win.
        drive_txn(1'b1, 1'b1, 1'b1, 1'b0, 32'h4, 32'h10, 32'hDEADBEEF, 1, 32'h12345678);
        n_tests++; if (t_stalls != 2) begin n_fail++; $display("FAIL store_stall_len: got %0d want 2", t_stalls); end
        n_tests++; if (t_we1 !== 1'b1) begin n_fail++; $display("FAIL store_we: got %b want 1", t_we1); end
        n_tests++; if (t_addr1 !== 32'h10) begin n_fail++; $display("FAIL store_addr: got %h want 00000010", t_addr1); end
        n_tests++; if (t_wdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_wdata: got %h want deadbeef", t_wdata1); end
        n_tests++; if (MDR !== 32'h0 || Instruction !== 32'h20080005) begin n_fail++; $display("FAIL store_regs: got mdr=%h ir=%h want 0 20080005", MDR, Instruction); end
        end_txn();
    endtask

    task automatic test_ack_idle();
        bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        n_tests++; if (MDR !== 32'h0 || Instruction !== 32'h20080005 || bus_req !== 1'b0) begin n_fail++; $display("FAIL ack_idle: got mdr=%h ir=%h req=%b want 0 20080005 0", MDR, Instruction, bus_req); end
    endtask

    task automatic test_load_mdr();
        drive_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 32'h20, 32'h0, 2, 32'hCAFEF00D);
        n_tests++; if (t_stalls != 3) begin n_fail++; $display("FAIL lw_stall_len: got %0d want 3", t_stalls); end
        n_tests++; if (t_addr1 !== 32'h20) begin n_fail++; $display("FAIL lw_addr: got %h want 00000020", t_addr1); end
        n_tests++; if (MDR !== 32'hCAFEF00D || Instruction !== 32'h20080005) begin n_fail++; $display("FAIL lw_data: got mdr=%h ir=%h want cafef00d 20080005", MDR, Instruction); end
        end_txn();
    endtask

    task automatic test_timeout();
        drive_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 32'h30, 32'h0, -1, 32'h99999999);
        n_tests++; if (t_stalls != 5) begin n_fail++; $display("FAIL to_stall_len: got %0d want 5", t_stalls); end
        n_tests++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL to_req: got %b want 0", bus_req); end
        n_tests++; if (MDR !== 32'h0) begin n_fail++; $display("FAIL to_mdr: got %h want 0", MDR); end
        n_tests++; if (TimeoutErr !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", TimeoutErr); end
        end_txn();
        drive_txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 32'h0, 1, 32'h11112222);
        n_tests++; if (Instruction !== 32'h11112222) begin n_fail++; $display("FAIL to_next_ir: got %h want 11112222", Instruction); end
        n_tests++; if (TimeoutErr !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", TimeoutErr); end
        end_txn();
    endtask

    task automatic test_ack_last_cycle();
        // Ack in the fourth (final) BUSY cycle must still deliver data.
        drive_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 32'h40, 32'h0, 4, 32'h0BADC0DE);
        n_tests++; if (t_stalls != 5 || MDR !== 32'h0BADC0DE) begin n_fail++; $display("FAIL ack_last: got stalls=%0d mdr=%h want 5 0badc0de", t_stalls, MDR); end
        end_txn();
    endtask

    task automatic test_reset_mid();
        MemRead = 1'b1; MemWrite = 1'b0; IorD = 1'b1; IRWrite = 1'b0; ALUOut = 32'h50;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL mid_busy_req: got %b want 1", bus_req); end
        reset = 1'b0; MemRead = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (bus_req !== 1'b0 || Stall !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got req=%b stall=%b want 0 0", bus_req, Stall); end
        n_tests++; if (TimeoutErr !== 1'b0 || MDR !== 32'h0 || Instruction !== 32'h0) begin n_fail++; $display("FAIL mid_clear: got err=%b mdr=%h ir=%h want 0 0 0", TimeoutErr, MDR, Instruction); end
        reset = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h55555555;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        n_tests++; if (MDR !== 32'h0 || Instruction !== 32'h0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL mid_late_ack: got mdr=%h ir=%h req=%b want 0 0 0", MDR, Instruction, bus_req); end
    endtask

    task automatic test_misalign();
        drive_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 32'h14, 32'h0, 1, 32'h77778888);
        end_txn();
        drive_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 32'h12, 32'h0, 1, 32'h13572468);
`ifdef MISALIGN_CHECK_EN
        n_tests++; if (t_stalls != 1 || t_any_req !== 1'b0) begin n_fail++; $display("FAIL mis_noreq: got stalls=%0d req=%b want 1 0", t_stalls, t_any_req); end
        n_tests++; if (AddrErr !== 1'b1) begin n_fail++; $display("FAIL mis_adderr: got %b want 1", AddrErr); end
        n_tests++; if (MDR !== 32'h77778888) begin n_fail++; $display("FAIL mis_mdr: got %h want 77778888", MDR); end
        end_txn();
        n_tests++; if (AddrErr !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %b want 0", AddrErr); end
`else
        n_tests++; if (t_addr1 !== 32'h12 || t_stalls != 2) begin n_fail++; $display("FAIL unaligned_pass: got addr=%h stalls=%0d want 00000012 2", t_addr1, t_stalls); end
        n_tests++; if (MDR !== 32'h13572468) begin n_fail++; $display("FAIL unaligned_mdr: got %h want 13572468", MDR); end
        end_txn();
`endif
    endtask

    initial begin
        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; IorD = 1'b0; IRWrite = 1'b0;
        PC = 32'h0; ALUOut = 32'h0; WriteData = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
        test_reset();
        test_fetch();
        test_store();
        test_ack_idle();
        test_load_mdr();
        test_timeout();
        test_ack_last_cycle();
        test_reset_mid();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
